mul_issue_ctrl: RTL

//  EX-stage controller wrapped around the 2-stage Wallace multiplier.
//  - Accepts MUL.W / MULH.W / MULH.WU ops from EX via valid/ready.
//  - Drives the multiplier's operand and sign inputs.
//  - Tracks ops in flight through the multiplier, which has no stall input.
//  - Buffers results in a credit-guarded FIFO and returns 32-bit results in order to the MEM stage.
//  - Cancels all in-flight work on pipeline flush.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_result_fifo.sv | 58 +++++
 rtl/mul_issue_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared encodings and helpers for the EX-stage multiply issue controller.
package mul_pkg;

   localparam int unsigned TAG_W = 5;

   typedef enum logic [1:0] {
      OP_MULW   = 2'b00,
      OP_MULHW  = 2'b01,
      OP_MULHWU = 2'b10,
      OP_RSVD   = 2'b11
   } mul_op_e;

   // Picks the architectural 32-bit word out of the full 64-bit product.
   function automatic logic [31:0] sel_word(input logic hi, input logic [63:0] prod64);
      return hi ? prod64[63:32] : prod64[31:0];
   endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Synchronous result FIFO with a register-array head; flush empties it in one cycle.
module mul_result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 37
) (
   input  logic                         mul_clk,
   input  logic                         resetn,
   input  logic                         flush,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;

   assign pop_ok = pop & (count_q != '0);
   assign head   = mem_q[rd_ptr_q];
   assign count  = count_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage controller around the fixed-latency multiplier: credit-guarded issue,
// tag/word-select delay line, in-order result FIFO and pipeline flush.
module mul_issue_ctrl #(
   parameter int unsigned MUL_LAT = 1,
   parameter int unsigned DEPTH   = MUL_LAT + 1,
   parameter int unsigned TAG_W   = mul_pkg::TAG_W
) (
   input  logic             mul_clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   output logic             mul_signed,
   input  logic [63:0]      mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   import mul_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]      credits_q, credits_d;
   logic               accept, pop, hi_sel, capture;
   logic [MUL_LAT-1:0] vld_q, hi_q;
   logic [TAG_W-1:0]   tag_q [MUL_LAT];
   logic [31:0]        cap_word;
   logic [CW-1:0]      fifo_count;
   logic [31+TAG_W:0]  fifo_head;

   // Operands go straight to the multiplier; unaccepted products are dropped via vld.
   assign mul_a      = in_src1;
   assign mul_b      = in_src2;
   assign mul_signed = (in_op != OP_MULHWU);
   assign hi_sel     = (in_op == OP_MULHW) || (in_op == OP_MULHWU);

   assign in_ready = (credits_q < DEPTH_C);
   assign accept   = in_valid & in_ready & ~flush;
   assign pop      = out_valid & out_ready & ~flush;
   assign busy     = (credits_q != '0);

   assign capture  = vld_q[MUL_LAT-1];
   assign cap_word = sel_word(hi_q[MUL_LAT-1], mul_result);

   always_ff @(posedge mul_clk) begin
      if (!resetn) begin
         vld_q <= '0;
         hi_q  <= '0;
         for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
      end else begin
         vld_q[0] <= accept;
         hi_q[0]  <= hi_sel;
         tag_q[0] <= in_tag;
         for (int i = 1; i < MUL_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            hi_q[i]  <= hi_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
         if (flush) vld_q <= '0;
      end
   end

   always_comb begin
      credits_d = credits_q;
      if (flush) begin
         credits_d = '0;
      end else begin
         case ({accept, pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
         endcase
      end
   end

   always_ff @(posedge mul_clk) begin
      if (!resetn) credits_q <= '0;
      else         credits_q <= credits_d;
   end

   // Credits bound in-flight + buffered ops to DEPTH, so capture never finds the FIFO full.
   mul_result_fifo #(
      .DEPTH (DEPTH),
      .W     (32 + TAG_W)
   ) u_fifo (
      .mul_clk   (mul_clk),
      .resetn    (resetn),
      .flush     (flush),
      .push      (capture),
      .push_data ({cap_word, tag_q[MUL_LAT-1]}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_head[31+TAG_W:TAG_W];
   assign out_tag   = fifo_head[TAG_W-1:0];

endmodule
